// File: rtl/result_collector.sv
// result_collector
// Gathers sparse per-core results into a single stream. Each core has a
// one-deep holding register. A round-robin arbiter moves one held result
// per cycle into a first-word-fall-through FIFO, tagged with the index of
// the core that produced it. Results that are overwritten before they are
// granted are counted as drops.
module result_collector #(
    parameter int NCORES = 38,
    parameter int DW     = 28,
    parameter int ENW    = 4,
    parameter int DEPTH  = 16,
    parameter int TW     = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCORES*DW-1:0]     core_data,
    input  logic [NCORES*ENW-1:0]    core_en,
    output logic [DW-1:0]            out_data,
    output logic [TW-1:0]            out_tag,
    output logic [ENW-1:0]           out_code,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic [15:0]              drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = TW + ENW + DW;

    // Holding registers
    logic [NCORES-1:0] r_pend;
    logic [ENW-1:0]    r_code [NCORES];
    logic [DW-1:0]     r_data [NCORES];
    logic [NCORES-1:0] w_cap;
    logic [NCORES-1:0] w_gnt_oh;
    logic [NCORES-1:0] w_drop;

    // Arbiter
    logic [TW-1:0]     r_rr_ptr;
    logic [TW-1:0]     w_gnt_idx;
    logic              w_gnt;

    // Status
    logic              r_overflow;
    logic [15:0]       r_drop_cnt;
    logic [16:0]       w_drop_sum;

    // FIFO
    logic [EW-1:0]     r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic              w_full;
    logic              w_pop;
    logic [EW-1:0]     w_head;

    for (genvar k = 0; k < NCORES; k++) begin : g_lane
        assign w_cap[k] = |core_en[k*ENW +: ENW];

        // Latch the lane's code and data whenever the core flags a result.
        always_ff @(posedge clk) begin
            if (!rst) begin
                r_code[k] <= '0;
                r_data[k] <= '0;
            end else if (w_cap[k]) begin
                r_code[k] <= core_en[k*ENW +: ENW];
                r_data[k] <= core_data[k*DW +: DW];
            end
        end
    end

    assign w_full = (r_count == CW'(DEPTH));
    assign w_pop  = (r_count != '0) && out_ready;

    // Round-robin search: first pending lane at or after r_rr_ptr, modulo NCORES.
    always_comb begin
        logic [TW:0] w_sum_idx;
        w_gnt     = 1'b0;
        w_gnt_idx = '0;
        w_sum_idx = '0;
        for (int i = 0; i < NCORES; i++) begin
            w_sum_idx = {1'b0, r_rr_ptr} + (TW+1)'(i);
            if (w_sum_idx >= (TW+1)'(NCORES))
                w_sum_idx = w_sum_idx - (TW+1)'(NCORES);
            if (!w_gnt && r_pend[w_sum_idx[TW-1:0]]) begin
                w_gnt     = 1'b1;
                w_gnt_idx = w_sum_idx[TW-1:0];
            end
        end
        // A full FIFO stalls the arbiter; held results simply wait.
        if (w_full)
            w_gnt = 1'b0;
    end

    // A capture on the granted lane reloads it and is not a drop.
    assign w_gnt_oh   = w_gnt ? (NCORES'(1) << w_gnt_idx) : '0;
    assign w_drop     = w_cap & r_pend & ~w_gnt_oh;
    assign w_drop_sum = {1'b0, r_drop_cnt} + 17'($countones(w_drop));

    // Pending flags, round-robin pointer and sticky drop accounting.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pend     <= '0;
            r_rr_ptr   <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_pend <= (r_pend & ~w_gnt_oh) | w_cap;
            if (w_gnt)
                r_rr_ptr <= (w_gnt_idx == TW'(NCORES-1)) ? '0 : w_gnt_idx + TW'(1);
            if (|w_drop) begin
                r_overflow <= 1'b1;
                r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
            end
        end
    end

    // FIFO storage; contents are don't-care until the pointers say otherwise.
    always_ff @(posedge clk) begin
        if (w_gnt)
            r_mem[r_wptr] <= {w_gnt_idx, r_code[w_gnt_idx], r_data[w_gnt_idx]};
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_gnt)
                r_wptr <= r_wptr + AW'(1);
            if (w_pop)
                r_rptr <= r_rptr + AW'(1);
            case ({w_gnt, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head     = r_mem[r_rptr];
    assign out_valid  = (r_count != '0);
    assign {out_tag, out_code, out_data} = out_valid ? w_head : '0;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_result_collector.sv
// Bench for result_collector: table of pulse vectors plus hand-written
// sequences for latency, FIFO-full, drop and mid-run reset behaviour.
// Expected entries go into a queue when stimulus is driven and are popped
// by a monitor when the DUT hands an entry to the consumer.
module tb_result_collector;

    localparam int NCORES = 38;
    localparam int DW     = 28;
    localparam int ENW    = 4;
    localparam int DEPTH  = 16;
    localparam int TW     = 6;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NCORES*DW-1:0]   core_data;
    logic [NCORES*ENW-1:0]  core_en;
    logic [DW-1:0]          out_data;
    logic [TW-1:0]          out_tag;
    logic [ENW-1:0]         out_code;
    logic                   out_valid;
    logic                   out_ready;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   overflow;
    logic [15:0]            drop_cnt;

    result_collector #(
        .NCORES(NCORES), .DW(DW), .ENW(ENW), .DEPTH(DEPTH), .TW(TW)
    ) dut (
        .clk(clk), .rst(rst), .core_data(core_data), .core_en(core_en),
        .out_data(out_data), .out_tag(out_tag), .out_code(out_code),
        .out_valid(out_valid), .out_ready(out_ready), .fifo_count(fifo_count),
        .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TW-1:0]  tag;
        logic [ENW-1:0] code;
        logic [DW-1:0]  data;
    } exp_t;

    typedef struct {
        int             a;
        logic [ENW-1:0] ca;
        logic [DW-1:0]  da;
        int             b;
        logic [ENW-1:0] cb;
        logic [DW-1:0]  db;
        int             first;
        int             second;
    } vec_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int k, input logic [ENW-1:0] c, input logic [DW-1:0] d);
        core_en[k*ENW +: ENW] = c;
        core_data[k*DW +: DW] = d;
    endtask

    task automatic push_exp(input int k, input logic [ENW-1:0] c, input logic [DW-1:0] d);
        exp_t e;
        e.tag  = TW'(k);
        e.code = c;
        e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb_q.size() == 0 && !out_valid) break;
            step();
        end
        check(name, sb_q.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        core_en = '0;
        step();
        step();
        rst = 1'b1;
    endtask

    function automatic logic [DW-1:0] lane_data(input int k);
        return DW'(k * 4097 + 3);
    endfunction

    function automatic logic [ENW-1:0] lane_code(input int k);
        return ENW'((k % 15) + 1);
    endfunction

    // Scoreboard monitor: an entry is consumed at the next edge when valid and ready.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got tag %0d data 0x%0h, expected no entry",
                         out_tag, out_data);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_tag",  32'(out_tag),  32'(e.tag));
                check("sb_code", 32'(out_code), 32'(e.code));
                check("sb_data", 32'(out_data), 32'(e.data));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        // rr_ptr entering the table is 6 (last grant was core 5)
        vecs[0] = '{a:4,  ca:4'd2,  da:28'h7FFFFFF, b:10, cb:4'd15, db:28'h8000000, first:10, second:4};
        vecs[1] = '{a:5,  ca:4'd8,  da:28'h0000000, b:37, cb:4'd1,  db:28'hFFFFFFF, first:5,  second:37};
        vecs[2] = '{a:37, ca:4'd3,  da:28'h1234567, b:0,  cb:4'd9,  db:28'hABCDEF0, first:0,  second:37};
        vecs[3] = '{a:20, ca:4'd4,  da:28'h0000001, b:-1, cb:4'd0,  db:28'h0000000, first:20, second:-1};
        vecs[4] = '{a:21, ca:4'd7,  da:28'h5555555, b:20, cb:4'd12, db:28'hAAAAAAA, first:21, second:20};
        vecs[5] = '{a:12, ca:4'd5,  da:28'h00FF00F, b:30, cb:4'd6,  db:28'hF00F00F, first:30, second:12};

        rst       = 1'b0;
        core_en   = '0;
        core_data = '0;
        out_ready = 1'b0;
        step();
        step();
        check("rst_valid",    32'(out_valid),  0);
        check("rst_count",    32'(fifo_count), 0);
        check("rst_overflow", 32'(overflow),   0);
        check("rst_drop_cnt", 32'(drop_cnt),   0);
        check("rst_data",     32'(out_data),   0);
        check("rst_tag",      32'(out_tag),    0);
        check("rst_code",     32'(out_code),   0);
        rst = 1'b1;
        out_ready = 1'b1;
        step();

        // Single pulse latency: visible one edge after grant, gone after pop.
        set_lane(5, 4'd1, 28'(-1234));
        push_exp(5, 4'd1, 28'(-1234));
        step();
        core_en = '0;
        check("lat_e0_valid", 32'(out_valid), 0);
        step();
        check("lat_e1_valid", 32'(out_valid), 1);
        step();
        check("lat_e2_valid", 32'(out_valid), 0);
        wait_drain("drain_single", 10);

        // Table of one- and two-lane pulses with round-robin ordering.
        for (int v = 0; v < 6; v++) begin
            set_lane(vecs[v].a, vecs[v].ca, vecs[v].da);
            if (vecs[v].b >= 0)
                set_lane(vecs[v].b, vecs[v].cb, vecs[v].db);
            if (vecs[v].first == vecs[v].a) begin
                push_exp(vecs[v].a, vecs[v].ca, vecs[v].da);
                if (vecs[v].b >= 0) push_exp(vecs[v].b, vecs[v].cb, vecs[v].db);
            end else begin
                push_exp(vecs[v].b, vecs[v].cb, vecs[v].db);
                push_exp(vecs[v].a, vecs[v].ca, vecs[v].da);
            end
            step();
            core_en = '0;
            wait_drain($sformatf("drain_vec%0d", v), 20);
        end

        // Cores 0, 7, 37 together from rr_ptr 0, then 1 and 36 to show the wrap.
        do_reset();
        set_lane(0,  lane_code(0),  lane_data(0));
        set_lane(7,  lane_code(7),  lane_data(7));
        set_lane(37, lane_code(37), lane_data(37));
        push_exp(0,  lane_code(0),  lane_data(0));
        push_exp(7,  lane_code(7),  lane_data(7));
        push_exp(37, lane_code(37), lane_data(37));
        step();
        core_en = '0;
        wait_drain("drain_rr3", 20);
        set_lane(36, lane_code(36), lane_data(36));
        set_lane(1,  lane_code(1),  lane_data(1));
        push_exp(1,  lane_code(1),  lane_data(1));
        push_exp(36, lane_code(36), lane_data(36));
        step();
        core_en = '0;
        wait_drain("drain_wrap", 20);

        // Move rr_ptr to 4 with a lone pulse on core 3.
        set_lane(3, lane_code(3), lane_data(3));
        push_exp(3, lane_code(3), lane_data(3));
        step();
        core_en = '0;
        wait_drain("drain_core3", 20);

        // 20 pulses with the consumer stalled: 20..35 fill the FIFO, 0..3 wait.
        out_ready = 1'b0;
        for (int k = 20; k <= 35; k++) begin
            set_lane(k, lane_code(k), lane_data(k));
            push_exp(k, lane_code(k), lane_data(k));
        end
        for (int k = 0; k <= 3; k++) set_lane(k, lane_code(k), lane_data(k));
        for (int k = 0; k <= 2; k++) push_exp(k, lane_code(k), lane_data(k));
        step();
        core_en = '0;
        repeat (25) step();
        check("full_count",    32'(fifo_count), 16);
        check("full_pend",     32'($countones(dut.r_pend)), 4);
        check("full_overflow", 32'(overflow), 0);

        // Overwrite the held result of core 3 while it waits.
        set_lane(3, 4'd6, 28'd99);
        push_exp(3, 4'd6, 28'd99);
        step();
        core_en = '0;
        check("drop_overflow", 32'(overflow),   1);
        check("drop_cnt",      32'(drop_cnt),   1);
        check("drop_count",    32'(fifo_count), 16);
        out_ready = 1'b1;
        wait_drain("drain_full", 80);
        check("drop_sticky", 32'(overflow), 1);

        // Reset with 6 entries queued; a pulse on the reset edge is discarded.
        out_ready = 1'b0;
        for (int k = 2; k <= 12; k += 2) set_lane(k, lane_code(k), lane_data(k));
        step();
        core_en = '0;
        repeat (10) step();
        check("pre_rst_count", 32'(fifo_count), 6);
        rst = 1'b0;
        set_lane(9, 4'd3, 28'h0123456);
        step();
        rst = 1'b1;
        core_en = '0;
        check("mid_rst_valid",    32'(out_valid),  0);
        check("mid_rst_count",    32'(fifo_count), 0);
        check("mid_rst_drop_cnt", 32'(drop_cnt),   0);
        check("mid_rst_overflow", 32'(overflow),   0);
        out_ready = 1'b1;
        repeat (6) step();
        check("post_rst_valid", 32'(out_valid),  0);
        check("post_rst_count", 32'(fifo_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
